// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the line-FIFO
// write arbiter. DATA/ADDR defaults match the line FIFO instance.
package fifo_arb_pkg;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 4;

  // Widest requester vector the helper handles; narrower vectors are
  // zero-extended by the caller.
  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // One-hot pick of the first asserted req bit at or after ptr, wrapping
  // modulo n. Returns zero when nothing in the low n bits is requesting.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input int ptr,
                                                  input int n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && (((req >> idx) & MAX_REQ'(1)) != '0)) begin
        pick  = MAX_REQ'(1) << idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick: first requester at or after ptr,
// wrapping, as a one-hot vector plus its encoded index.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               any
);

  logic [MAX_REQ-1:0] pick_ext;

  // Rotating priority search over the zero-extended request vector.
  always_comb begin
    pick_ext = rr_pick(MAX_REQ'(req), int'(ptr), NUM_REQ);
  end

  assign pick = pick_ext[NUM_REQ-1:0];
  assign any  = |pick_ext;

  // Encode the one-hot pick; only one bit can be set.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter for the line FIFO: round-robin grants with bounded
// bursts, registered write port, own occupancy tracking (the FIFO has no
// flags) and pass-through of consumer read acknowledges.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; grant the first requester from rr_ptr (wrapping)
//   BURST | owner keeps the port while it requests, space remains and
//         | fewer than MAX_BURST words have been accepted
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                           clk,
  input  logic                           nRST,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [DATA_SIZE-1:0]           fifo_data_in,
  output logic                           fifo_w_e,
  input  logic                           cons_r_ack,
  output logic                           fifo_r_ack,
  output logic [ADDR_SIZE:0]             level,
  output logic                           empty,
  output logic                           full
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam int LVL_W = ADDR_SIZE + 1;

  localparam logic [0:0]       S_IDLE   = 1'(IDLE);
  localparam logic [0:0]       S_BURST  = 1'(BURST);
  localparam logic [LVL_W-1:0] DEPTH    = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic [0:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   burst_cnt;
  logic [LVL_W-1:0]   rd_count;

  logic [NUM_REQ-1:0] pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  logic               space;
  logic [NUM_REQ-1:0] gnt_c;
  logic               accept;
  logic               burst_end;
  logic [PTR_W-1:0]   acc_idx;
  logic [DATA_SIZE-1:0] acc_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign space = (level < DEPTH);

  // Grant decode: IDLE takes the round-robin pick, BURST only the owner.
  // Held at zero while reset is asserted so no accept is seen mid-reset.
  always_comb begin
    gnt_c     = '0;
    accept    = 1'b0;
    burst_end = 1'b0;
    acc_idx   = owner;
    case (state)
      S_IDLE: begin
        if (space && pick_any) begin
          gnt_c   = pick_oh;
          accept  = 1'b1;
          acc_idx = pick_idx;
        end
      end
      S_BURST: begin
        if (space && req[owner]) begin
          gnt_c[owner] = 1'b1;
          accept       = 1'b1;
          burst_end    = (burst_cnt == LAST_CNT);
        end else begin
          burst_end = 1'b1;
        end
      end
      default: ;
    endcase
    if (nRST) begin
      gnt_c     = '0;
      accept    = 1'b0;
      burst_end = 1'b0;
    end
  end

  assign gnt = gnt_c;

  // Slice of the word being accepted this cycle.
  always_comb begin
    acc_data = req_data[int'(acc_idx)*DATA_SIZE +: DATA_SIZE];
  end

  // Ownership FSM: burst tracking and round-robin pointer rotation.
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner     <= pick_idx;
            burst_cnt <= CNT_W'(1);
            if (MAX_BURST > 1) begin
              state <= S_BURST;
            end else begin
              rr_ptr <= ptr_inc(pick_idx);
            end
          end
        end
        S_BURST: begin
          if (accept) burst_cnt <= burst_cnt + 1'b1;
          if (burst_end) begin
            state  <= S_IDLE;
            rr_ptr <= ptr_inc(owner);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered FIFO write port; data holds between accepts.
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      fifo_w_e     <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_w_e <= accept;
      if (accept) fifo_data_in <= acc_data;
    end
  end

  // Reads only reach the FIFO when a landed word exists.
  assign fifo_r_ack = cons_r_ack & ~empty;

  // level counts committed words (in-flight included); rd_count counts
  // words that have actually landed, which is what gates reads.
  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      level    <= '0;
      rd_count <= '0;
    end else begin
      case ({accept, fifo_r_ack})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      case ({fifo_w_e, fifo_r_ack})
        2'b10:   rd_count <= rd_count + 1'b1;
        2'b01:   rd_count <= rd_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign empty = (rd_count == '0);
  assign full  = (level == DEPTH);

endmodule
